// File: rtl/wb_ext_pkg.sv
// Shared types and width helpers for the Wishbone-to-ext bridge.
package wb_ext_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic {OK, ERR} resp_t;

    // Channel-select field width; a single channel still gets one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_ext_rdmux.sv
// NUM_CH:1 read-data slice select, indexed by the latched channel.
module wb_ext_rdmux
    import wb_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2,
    parameter int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH*DATA_W-1:0] rd_bus,
    input  logic [CH_W-1:0]          ch,
    output logic [DATA_W-1:0]        rd_data
);

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == CH_W'(c)) rd_data = rd_bus[c*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/wb_ext_bridge.sv
// Registered Wishbone-classic slave fanning single cycles out to NUM_CH ext buses.
// Define WB_EXT_TIMEOUT_EN to build the REQ timeout counter, timeout_irq and timeout errors.
module wb_ext_bridge
    import wb_ext_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_CH     = 2,
    parameter int CH_SEL_LSB = 28,
    parameter int TIMEOUT    = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [DATA_W/8-1:0]      wbs_sel_i,
    input  logic [ADDR_W-1:0]        wbs_adr_i,
    input  logic [DATA_W-1:0]        wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic                     wbs_err_o,
    output logic [DATA_W-1:0]        wbs_dat_o,
    output logic [NUM_CH-1:0]        ext_valid,
    output logic                     ext_write,
    output logic [ADDR_W-1:0]        ext_address,
    output logic [DATA_W-1:0]        ext_write_data,
    output logic [DATA_W/8-1:0]      ext_write_strobe,
    input  logic [NUM_CH-1:0]        ext_ready,
    input  logic [NUM_CH*DATA_W-1:0] ext_read_data,
    output logic                     timeout_irq
);

    localparam int                CH_W      = ch_width(NUM_CH);
    localparam logic [CH_W:0]     CH_LIMIT  = (CH_W+1)'(NUM_CH);
    localparam logic [NUM_CH-1:0] CH0_ONEHOT = NUM_CH'(1);

    state_t            state, state_nxt;
    resp_t             resp;
    logic [CH_W-1:0]   ch;
    logic [CH_W-1:0]   adr_ch;
    logic              adr_ch_ok;
    logic [DATA_W-1:0] rd_data;
    logic              accept, dec_err, done_ok, tmo, resp_fire;
    logic              timeout_hit;

    assign adr_ch    = wbs_adr_i[CH_SEL_LSB +: CH_W];
    assign adr_ch_ok = {1'b0, adr_ch} < CH_LIMIT;

    wb_ext_rdmux #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W)) u_rdmux (
        .rd_bus  (ext_read_data),
        .ch      (ch),
        .rd_data (rd_data)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        dec_err   = 1'b0;
        done_ok   = 1'b0;
        tmo       = 1'b0;
        resp_fire = 1'b0;
        case (state)
            IDLE: begin
                // The master still holds stb while our ack/err is on the bus.
                if (wbs_cyc_i && wbs_stb_i && !wbs_ack_o && !wbs_err_o) begin
                    if (adr_ch_ok) begin
                        accept    = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        dec_err   = 1'b1;
                        state_nxt = RESP;
                    end
                end
            end
            REQ: begin
                if (ext_ready[ch]) begin
                    done_ok   = 1'b1;
                    state_nxt = RESP;
                end else if (timeout_hit) begin
                    tmo       = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_fire = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            resp             <= OK;
            ch               <= '0;
            wbs_ack_o        <= 1'b0;
            wbs_err_o        <= 1'b0;
            wbs_dat_o        <= '0;
            ext_valid        <= '0;
            ext_write        <= 1'b0;
            ext_address      <= '0;
            ext_write_data   <= '0;
            ext_write_strobe <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            if (accept) begin
                ch               <= adr_ch;
                ext_valid        <= CH0_ONEHOT << adr_ch;
                ext_write        <= wbs_we_i;
                ext_address      <= wbs_adr_i;
                ext_write_data   <= wbs_dat_i;
                ext_write_strobe <= wbs_sel_i;
            end
            if (dec_err) begin
                resp      <= ERR;
                wbs_dat_o <= '0;
            end
            if (done_ok) begin
                ext_valid <= '0;
                resp      <= OK;
                wbs_dat_o <= ext_write ? '0 : rd_data;
            end
            if (tmo) begin
                ext_valid <= '0;
                resp      <= ERR;
                wbs_dat_o <= '0;
            end
            // An abandoned cycle still drains the ext side but is never answered.
            if (resp_fire && wbs_cyc_i) begin
                wbs_ack_o <= (resp == OK);
                wbs_err_o <= (resp == ERR);
            end
        end
    end

`ifdef WB_EXT_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state != REQ) cnt <= '0;
        else                          cnt <= cnt + 1'b1;
    end

    // Fires in the TIMEOUT-th REQ cycle, i.e. when the post-increment count reaches TIMEOUT.
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) timeout_irq <= 1'b0;
        else          timeout_irq <= tmo;
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_wb_ext_bridge.sv
// Scoreboard bench for wb_ext_bridge: directed Wishbone cycles, ext-side responder, response monitor.
module tb_wb_ext_bridge;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NUM_CH  = 3;
    localparam int TIMEOUT = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]               wbs_sel_i;
    logic [ADDR_W-1:0]        wbs_adr_i;
    logic [DATA_W-1:0]        wbs_dat_i;
    logic                     wbs_ack_o, wbs_err_o;
    logic [DATA_W-1:0]        wbs_dat_o;
    logic [NUM_CH-1:0]        ext_valid;
    logic                     ext_write;
    logic [ADDR_W-1:0]        ext_address;
    logic [DATA_W-1:0]        ext_write_data;
    logic [3:0]               ext_write_strobe;
    logic [NUM_CH-1:0]        ext_ready;
    logic [NUM_CH*DATA_W-1:0] ext_read_data;
    logic                     timeout_irq;

    wb_ext_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_SEL_LSB(28), .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_dat_o(wbs_dat_o),
        .ext_valid(ext_valid), .ext_write(ext_write), .ext_address(ext_address),
        .ext_write_data(ext_write_data), .ext_write_strobe(ext_write_strobe),
        .ext_ready(ext_ready), .ext_read_data(ext_read_data), .timeout_irq(timeout_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_err;
        bit          chk_dat;
        logic [31:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    int cyc_n = 0;
    always @(posedge clk) cyc_n++;

    // Response monitor
    int resp_count = 0, irq_count = 0, last_resp_cyc = 0, last_irq_cyc = 0;
    bit prev_resp = 1'b0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (timeout_irq) begin
            irq_count++;
            last_irq_cyc = cyc_n;
        end
        if (wbs_ack_o || wbs_err_o) begin
            resp_count++;
            last_resp_cyc = cyc_n;
            chk("resp_single_cycle", 64'(prev_resp), 64'd0);
            chk("ack_err_exclusive", 64'(wbs_ack_o & wbs_err_o), 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: ack=%0b err=%0b, expected no response", wbs_ack_o, wbs_err_o);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, "_kind"}, 64'({wbs_ack_o, wbs_err_o}), e.is_err ? 64'b01 : 64'b10);
                if (e.chk_dat) chk({e.name, "_dat"}, 64'(wbs_dat_o), 64'(e.dat));
            end
        end
        prev_resp = wbs_ack_o | wbs_err_o;
    end

    // Ext-side responder: ready in the rdy_delay-th valid cycle (0 = never) or when rdy_now
    int          rdy_delay = 0;
    bit          rdy_now = 1'b0;
    int          vcnt = 0, last_vlen = 0, valid_total = 0;
    logic [NUM_CH-1:0] vpat = '0;
    bit          unstable = 1'b0;
    logic        snap_we = 1'b0;
    logic [31:0] snap_adr = '0, snap_dat = '0;
    logic [3:0]  snap_sel = '0;

    initial begin
        ext_ready = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ext_valid != '0) begin
                vcnt++;
                valid_total++;
                if (vcnt == 1) begin
                    vpat = ext_valid; snap_we = ext_write; snap_adr = ext_address;
                    snap_dat = ext_write_data; snap_sel = ext_write_strobe; unstable = 1'b0;
                end else if (ext_valid !== vpat || ext_write !== snap_we || ext_address !== snap_adr ||
                             ext_write_data !== snap_dat || ext_write_strobe !== snap_sel) begin
                    unstable = 1'b1;
                end
                ext_ready = (vcnt == rdy_delay || rdy_now) ? ext_valid : '0;
            end else begin
                if (vcnt != 0) last_vlen = vcnt;
                vcnt = 0;
                ext_ready = '0;
            end
        end
    end

    task automatic start_cyc(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output int acc);
        @(posedge clk);
        #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        acc = cyc_n + 1;
    endtask

    task automatic end_cyc();
        @(posedge clk);
        #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wait_resp(input string name, input int max, output int resp_edge);
        int n = 0;
        resp_edge = -1;
        while (!(wbs_ack_o || wbs_err_o) && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (wbs_ack_o || wbs_err_o) resp_edge = cyc_n;
        else begin
            checks++;
            errors++;
            $display("FAIL %s_wait: no ack/err within %0d cycles, expected a response", name, max);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, redge, ic, rc, vt;
        rst = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
        ext_read_data = {32'h5A5A_C3C3, 32'h1234_5678, 32'hA5A5_0F0F};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ext_valid", 64'(ext_valid), 64'd0);
        chk("rst_ack_err_irq", 64'({wbs_ack_o, wbs_err_o, timeout_irq}), 64'd0);
        chk("rst_dat_o", 64'(wbs_dat_o), 64'd0);
        chk("rst_ext_shared", 64'({ext_write, ext_address, ext_write_strobe}), 64'd0);

        // Write to ch0, ready in the second valid cycle
        rdy_delay = 2;
        exp_q.push_back('{name: "wr_ch0", is_err: 1'b0, chk_dat: 1'b0, dat: 32'h0});
        start_cyc(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, acc);
        wait_resp("wr_ch0", 20, redge);
        end_cyc();
        @(negedge clk);
        chk("wr_vpat", 64'(vpat), 64'b001);
        chk("wr_vlen", 64'(last_vlen), 64'd2);
        chk("wr_stable", 64'(unstable), 64'd0);
        chk("wr_we_sel", 64'({snap_we, snap_sel}), 64'h1F);
        chk("wr_adr_dat", {snap_adr, snap_dat}, 64'h0000_0010_DEAD_BEEF);

        // Read from ch1 with immediate ready: master samples ack 3 edges after accept
        rdy_delay = 1;
        exp_q.push_back('{name: "rd_ch1", is_err: 1'b0, chk_dat: 1'b1, dat: 32'h1234_5678});
        start_cyc(1'b0, 32'h1000_0020, 32'h0, 4'hF, acc);
        wait_resp("rd_ch1", 20, redge);
        end_cyc();
        @(negedge clk);
        chk("rd_vpat", 64'(vpat), 64'b010);
        chk("rd_latency", 64'(redge - acc + 1), 64'd3);
        chk("rd_vlen", 64'(last_vlen), 64'd1);

        // Channel index 3 with NUM_CH=3 is a decode error
        vt = valid_total; ic = irq_count;
        exp_q.push_back('{name: "dec_err", is_err: 1'b1, chk_dat: 1'b1, dat: 32'h0});
        start_cyc(1'b0, 32'h3000_0000, 32'h0, 4'hF, acc);
        wait_resp("dec_err", 20, redge);
        end_cyc();
        @(negedge clk);
        chk("dec_no_ext", 64'(valid_total - vt), 64'd0);
        chk("dec_no_irq", 64'(irq_count - ic), 64'd0);

        // ch0 never ready
        rdy_delay = 0; ic = irq_count; rc = resp_count;
`ifdef WB_EXT_TIMEOUT_EN
        exp_q.push_back('{name: "tmo", is_err: 1'b1, chk_dat: 1'b1, dat: 32'h0});
        start_cyc(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'h3, acc);
        wait_resp("tmo", 40, redge);
        end_cyc();
        @(negedge clk);
        chk("tmo_vlen", 64'(last_vlen), 64'(TIMEOUT));
        chk("tmo_irq_pulses", 64'(irq_count - ic), 64'd1);
        chk("tmo_err_after_irq", 64'(last_resp_cyc - last_irq_cyc), 64'd1);
`else
        start_cyc(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'h3, acc);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk("notmo_still_valid", 64'(ext_valid), 64'b001);
        chk("notmo_no_resp", 64'(resp_count - rc), 64'd0);
        chk("notmo_no_irq", 64'(irq_count - ic), 64'd0);
        exp_q.push_back('{name: "notmo_release", is_err: 1'b0, chk_dat: 1'b0, dat: 32'h0});
        rdy_now = 1'b1;
        wait_resp("notmo_release", 10, redge);
        rdy_now = 1'b0;
        end_cyc();
`endif

        // Ready in the same cycle the counter reaches TIMEOUT: ready wins
        rdy_delay = TIMEOUT; ic = irq_count;
        exp_q.push_back('{name: "coincide", is_err: 1'b0, chk_dat: 1'b1, dat: 32'hA5A5_0F0F});
        start_cyc(1'b0, 32'h0000_0080, 32'h0, 4'hF, acc);
        wait_resp("coincide", 40, redge);
        end_cyc();
        @(negedge clk);
        chk("coin_vlen", 64'(last_vlen), 64'(TIMEOUT));
        chk("coin_no_irq", 64'(irq_count - ic), 64'd0);

        // Reset in the middle of REQ
        rdy_delay = 0; rc = resp_count;
        start_cyc(1'b0, 32'h1000_0000, 32'h0, 4'hF, acc);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ext_valid", 64'(ext_valid), 64'd0);
        chk("mid_rst_ack_err_irq", 64'({wbs_ack_o, wbs_err_o, timeout_irq}), 64'd0);
        chk("mid_rst_dat_o", 64'(wbs_dat_o), 64'd0);
        chk("mid_rst_shared", 64'({ext_write, ext_address, ext_write_strobe}), 64'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_no_resp", 64'(resp_count - rc), 64'd0);

        // Master abandons the cycle during REQ
        rdy_delay = 4; rc = resp_count;
        start_cyc(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'hC, acc);
        @(posedge clk);
        #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("drop_vlen", 64'(last_vlen), 64'd4);
        chk("drop_no_resp", 64'(resp_count - rc), 64'd0);
        chk("drop_ext_idle", 64'(ext_valid), 64'd0);

        // Bridge is usable again afterwards
        rdy_delay = 1;
        exp_q.push_back('{name: "post_drop_rd", is_err: 1'b0, chk_dat: 1'b1, dat: 32'h1234_5678});
        start_cyc(1'b0, 32'h1000_0004, 32'h0, 4'hF, acc);
        wait_resp("post_drop_rd", 20, redge);
        end_cyc();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
